// File: rtl/uart_tx.sv
// UART transmitter: start bit, payload LSB first, optional parity, stop bit(s).
// Line and busy are registered copies of the next-state decode, so uart_txd has no input-to-pin path.
module uart_tx #(
    parameter int BIT_RATE     = 115200,
    parameter int CLK_HZ       = 50000000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                    clk,
    input  logic                    resetn,
    output logic                    uart_txd,
    output logic                    uart_tx_busy,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
    localparam int IDX_W          = 3;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    if (CYCLES_PER_BIT < 2 || PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
        $error("uart_tx: illegal parameter set");
    end

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic [PAYLOAD_BITS-1:0] r_data;
    logic                    r_txd;
    logic                    r_busy;

    state_t                  w_state;
    logic [CNT_W-1:0]        w_cnt;
    logic [IDX_W-1:0]        w_idx;
    logic [PAYLOAD_BITS-1:0] w_shift;
    logic [PAYLOAD_BITS-1:0] w_data;
    logic                    w_txd;
    logic                    w_busy;
    logic                    w_bit_end;
    logic                    w_parity;

    assign w_bit_end = (r_cnt == CNT_W'(CYCLES_PER_BIT - 1));
    // Parity uses the captured word because r_shift is consumed while DATA runs.
    assign w_parity  = (^r_data) ^ 1'(PARITY_ODD);

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_shift = r_shift;
        w_data  = r_data;
        case (r_state)
            IDLE: begin
                if (uart_tx_en) begin
                    w_state = START;
                    w_cnt   = '0;
                    w_idx   = '0;
                    w_shift = uart_tx_data;
                    w_data  = uart_tx_data;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state = DATA;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt   = '0;
                    w_shift = r_shift >> 1;
                    if (r_idx == IDX_W'(PAYLOAD_BITS - 1)) begin
                        w_idx   = '0;
                        w_state = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_idx = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state = STOP;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_cnt = '0;
                    if (r_idx == IDX_W'(STOP_BITS - 1)) begin
                        w_idx   = '0;
                        w_state = IDLE;
                    end else begin
                        w_idx = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_comb begin
        w_txd  = 1'b1;
        w_busy = (w_state != IDLE);
        case (w_state)
            START:   w_txd = 1'b0;
            DATA:    w_txd = w_shift[0];
            PARITY:  w_txd = w_parity;
            default: w_txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_shift <= w_shift;
            r_data  <= w_data;
            r_txd   <= w_txd;
            r_busy  <= w_busy;
        end
    end

    assign uart_txd     = r_txd;
    assign uart_tx_busy = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: five differently parameterised instances checked cycle-by-cycle
// against a frame model built from the start/payload/parity/stop rules.
module tb_uart_tx;

    localparam int N = 5;
    localparam int CFG_CPB [N] = '{434, 434, 434, 4, 2};
    localparam int CFG_PB  [N] = '{8, 8, 8, 5, 6};
    localparam int CFG_SB  [N] = '{1, 1, 1, 2, 1};
    localparam int CFG_PE  [N] = '{0, 1, 1, 1, 0};
    localparam int CFG_PO  [N] = '{0, 0, 1, 1, 0};

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [N-1:0] en;
    logic [7:0]   tx_data [N];
    wire  [N-1:0] txd_w;
    wire  [N-1:0] busy_w;

    int   n_vec = 0;
    int   n_bad = 0;
    logic exp_q[$];
    logic got_txd[$];
    logic got_busy[$];

    always #5 clk = ~clk;

    uart_tx dut0 (
        .clk(clk), .resetn(resetn), .uart_txd(txd_w[0]), .uart_tx_busy(busy_w[0]),
        .uart_tx_en(en[0]), .uart_tx_data(tx_data[0])
    );
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .resetn(resetn), .uart_txd(txd_w[1]), .uart_tx_busy(busy_w[1]),
        .uart_tx_en(en[1]), .uart_tx_data(tx_data[1])
    );
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .resetn(resetn), .uart_txd(txd_w[2]), .uart_tx_busy(busy_w[2]),
        .uart_tx_en(en[2]), .uart_tx_data(tx_data[2])
    );
    uart_tx #(.CLK_HZ(400), .BIT_RATE(100), .PAYLOAD_BITS(5), .STOP_BITS(2),
              .PARITY_EN(1), .PARITY_ODD(1)) dut3 (
        .clk(clk), .resetn(resetn), .uart_txd(txd_w[3]), .uart_tx_busy(busy_w[3]),
        .uart_tx_en(en[3]), .uart_tx_data(tx_data[3][4:0])
    );
    uart_tx #(.CLK_HZ(200), .BIT_RATE(100), .PAYLOAD_BITS(6), .STOP_BITS(1)) dut4 (
        .clk(clk), .resetn(resetn), .uart_txd(txd_w[4]), .uart_tx_busy(busy_w[4]),
        .uart_tx_en(en[4]), .uart_tx_data(tx_data[4][5:0])
    );

    // Reference: the list of line levels, one entry per bit period.
    task automatic model_frame(input int k, input logic [7:0] d);
        logic [7:0] w;
        exp_q.delete();
        w = d & 8'((1 << CFG_PB[k]) - 1);
        exp_q.push_back(1'b0);
        for (int i = 0; i < CFG_PB[k]; i++) exp_q.push_back(w[i]);
        if (CFG_PE[k] != 0) exp_q.push_back((^w) ^ 1'(CFG_PO[k]));
        for (int i = 0; i < CFG_SB[k]; i++) exp_q.push_back(1'b1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int k, input logic [7:0] d, input bit hold);
        en[k] = 1'b1;
        tx_data[k] = d;
        step(1);
        if (!hold) en[k] = 1'b0;
        tx_data[k] = 8'($urandom);
    endtask

    task automatic capture(input int k, input int n, input int pulse_at, input logic [7:0] pulse_d);
        got_txd.delete();
        got_busy.delete();
        for (int c = 0; c < n; c++) begin
            got_txd.push_back(txd_w[k]);
            got_busy.push_back(busy_w[k]);
            if (c == pulse_at) begin
                en[k] = 1'b1;
                tx_data[k] = pulse_d;
            end else if (pulse_at >= 0 && c == pulse_at + 1) begin
                en[k] = 1'b0;
            end
            step(1);
        end
    endtask

    function automatic int wave_first_bad(input int k);
        for (int i = 0; i < got_txd.size(); i++)
            if (got_txd[i] !== exp_q[i / CFG_CPB[k]]) return i;
        return -1;
    endfunction

    function automatic int busy_high();
        int n = 0;
        foreach (got_busy[i]) if (got_busy[i] === 1'b1) n++;
        return n;
    endfunction

    task automatic test_reset();
        step(3);
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if (txd_w[k] !== 1'b1 || busy_w[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state[%0d]: txd=%b busy=%b expected txd=1 busy=0", k, txd_w[k], busy_w[k]);
            end
        end
        resetn = 1'b1;
        step(2);
    endtask

    task automatic test_single_a5();
        int bad;
        send(0, 8'hA5, 1'b0);
        model_frame(0, 8'hA5);
        capture(0, exp_q.size() * CFG_CPB[0], -1, 8'h00);
        bad = wave_first_bad(0);
        n_vec++;
        if (bad >= 0) begin
            n_bad++;
            $display("FAIL a5_wave: cycle %0d txd=%b expected %b", bad, got_txd[bad], exp_q[bad / CFG_CPB[0]]);
        end
        n_vec++;
        if (busy_high() !== 4340) begin
            n_bad++;
            $display("FAIL a5_busy_len: got %0d cycles expected 4340", busy_high());
        end
        n_vec++;
        if (busy_w[0] !== 1'b0 || txd_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL a5_idle: busy=%b txd=%b expected busy=0 txd=1", busy_w[0], txd_w[0]);
        end
    endtask

    task automatic test_ignore_busy();
        int bad;
        send(0, 8'h55, 1'b0);
        model_frame(0, 8'h55);
        capture(0, exp_q.size() * CFG_CPB[0], 5 * CFG_CPB[0], 8'h3C);
        bad = wave_first_bad(0);
        n_vec++;
        if (bad >= 0) begin
            n_bad++;
            $display("FAIL ignore_wave: cycle %0d txd=%b expected %b", bad, got_txd[bad], exp_q[bad / CFG_CPB[0]]);
        end
        capture(0, 3 * CFG_CPB[0], -1, 8'h00);
        bad = -1;
        foreach (got_txd[i]) if (bad < 0 && (got_txd[i] !== 1'b1 || got_busy[i] !== 1'b0)) bad = i;
        n_vec++;
        if (bad >= 0) begin
            n_bad++;
            $display("FAIL ignore_no_second: cycle %0d txd=%b busy=%b expected txd=1 busy=0", bad, got_txd[bad], got_busy[bad]);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        send(0, 8'h01, 1'b1);
        tx_data[0] = 8'hFF;
        model_frame(0, 8'h01);
        capture(0, exp_q.size() * CFG_CPB[0], -1, 8'h00);
        bad = wave_first_bad(0);
        n_vec++;
        if (bad >= 0) begin
            n_bad++;
            $display("FAIL b2b_wave1: cycle %0d txd=%b expected %b", bad, got_txd[bad], exp_q[bad / CFG_CPB[0]]);
        end
        n_vec++;
        if (busy_w[0] !== 1'b0 || txd_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_idle_cycle: busy=%b txd=%b expected busy=0 txd=1", busy_w[0], txd_w[0]);
        end
        step(1);
        en[0] = 1'b0;
        model_frame(0, 8'hFF);
        capture(0, exp_q.size() * CFG_CPB[0], -1, 8'h00);
        n_vec++;
        if (got_txd[0] !== 1'b0 || got_busy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_gap: txd=%b busy=%b one cycle after busy drop, expected txd=0 busy=1", got_txd[0], got_busy[0]);
        end
        bad = wave_first_bad(0);
        n_vec++;
        if (bad >= 0) begin
            n_bad++;
            $display("FAIL b2b_wave2: cycle %0d txd=%b expected %b", bad, got_txd[bad], exp_q[bad / CFG_CPB[0]]);
        end
    endtask

    task automatic test_parity();
        int bad;
        logic [7:0] d;
        for (int k = 1; k <= 2; k++) begin
            for (int f = 0; f < 2; f++) begin
                d = (f == 0) ? 8'h07 : 8'($urandom);
                send(k, d, 1'b0);
                model_frame(k, d);
                capture(k, exp_q.size() * CFG_CPB[k], -1, 8'h00);
                bad = wave_first_bad(k);
                n_vec++;
                if (bad >= 0) begin
                    n_bad++;
                    $display("FAIL parity_wave[%0d] d=%h: cycle %0d txd=%b expected %b", k, d, bad, got_txd[bad], exp_q[bad / CFG_CPB[k]]);
                end
                if (f == 0) begin
                    n_vec++;
                    if (got_txd[9 * 434 + 217] !== ((k == 1) ? 1'b1 : 1'b0)) begin
                        n_bad++;
                        $display("FAIL parity_bit_07[%0d]: got %b expected %b", k, got_txd[9 * 434 + 217], (k == 1) ? 1'b1 : 1'b0);
                    end
                    n_vec++;
                    if (busy_high() !== 11 * 434) begin
                        n_bad++;
                        $display("FAIL parity_len[%0d]: got %0d expected %0d", k, busy_high(), 11 * 434);
                    end
                end
                n_vec++;
                if (busy_w[k] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL parity_idle[%0d]: busy=%b expected 0", k, busy_w[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        logic [7:0] d;
        send(0, 8'h00, 1'b0);
        step(4 * CFG_CPB[0] + 217);
        #2;
        resetn = 1'b0;
        #1;
        n_vec++;
        if (txd_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_frame: txd=%b busy=%b expected txd=1 busy=0", txd_w[0], busy_w[0]);
        end
        #3;
        resetn = 1'b1;
        step(2);
        d = 8'($urandom);
        send(0, d, 1'b0);
        model_frame(0, d);
        capture(0, exp_q.size() * CFG_CPB[0], -1, 8'h00);
        bad = wave_first_bad(0);
        n_vec++;
        if (bad >= 0) begin
            n_bad++;
            $display("FAIL post_reset_wave d=%h: cycle %0d txd=%b expected %b", d, bad, got_txd[bad], exp_q[bad / CFG_CPB[0]]);
        end
        n_vec++;
        if (busy_high() !== 4340 || busy_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_busy: got %0d cycles then busy=%b, expected 4340 then 0", busy_high(), busy_w[0]);
        end
    endtask

    task automatic test_random();
        int bad;
        int k;
        int nf;
        logic [7:0] d;
        for (int s = 0; s < 3; s++) begin
            k  = (s == 0) ? 0 : s + 2;
            nf = (s == 0) ? 2 : 20;
            for (int f = 0; f < nf; f++) begin
                step($urandom_range(0, 3));
                d = 8'($urandom);
                send(k, d, 1'b0);
                model_frame(k, d);
                capture(k, exp_q.size() * CFG_CPB[k], -1, 8'h00);
                bad = wave_first_bad(k);
                n_vec++;
                if (bad >= 0) begin
                    n_bad++;
                    $display("FAIL random_wave[%0d] d=%h: cycle %0d txd=%b expected %b", k, d, bad, got_txd[bad], exp_q[bad / CFG_CPB[k]]);
                end
                n_vec++;
                if (busy_high() !== exp_q.size() * CFG_CPB[k] || busy_w[k] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL random_busy[%0d] d=%h: got %0d cycles then busy=%b, expected %0d then 0", k, d, busy_high(), busy_w[k], exp_q.size() * CFG_CPB[k]);
                end
            end
        end
    endtask

    initial begin
        en = '0;
        for (int k = 0; k < N; k++) tx_data[k] = 8'h00;
        test_reset();
        test_single_a5();
        test_ignore_busy();
        test_back_to_back();
        test_parity();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
